// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer slice.
//   state_t       : sequencer FSM states
//   DEFAULT_REP_W : default width of repeat / completed counts
package timer_pkg;

    localparam int DEFAULT_REP_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        ARM  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/timer_sequencer_if.sv
// Command / response handshake bundle of the timer sequencer.
//   cmd_valid, cmd_ready, cmd_reps            : command channel
//   rsp_valid, rsp_ready, rsp_count, rsp_aborted : response channel
// master = command issuer / response consumer, slave = sequencer.
interface timer_sequencer_if #(
    parameter int REP_W = timer_pkg::DEFAULT_REP_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [REP_W-1:0] cmd_reps;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [REP_W-1:0] rsp_count;
    logic             rsp_aborted;

    modport master (
        output cmd_valid, cmd_reps, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, rsp_aborted
    );

    modport slave (
        input  cmd_valid, cmd_reps, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, rsp_aborted
    );
endinterface

// File: rtl/timer_sequencer.sv
// Command-driven controller upstream of a one-shot timer. A command carries a
// repeat count; the timer is started once per period, completions are counted,
// a tick is emitted per period and one response is returned per command.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : cmd_valid/cmd_ready/cmd_reps, rsp_valid/rsp_ready/
//                  rsp_count/rsp_aborted
//   abort        : request stop at the end of the current period
//   timer_go     : one-cycle start pulse to the timer
//   timer_done   : timer idle or in its final active cycle
//   tick         : one-cycle pulse per completed period
//   busy         : a command is in progress
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int REP_W = DEFAULT_REP_W
) (
    input  logic                clk,
    input  logic                rst,
    timer_sequencer_if.slave    bus,
    input  logic                abort,
    output logic                timer_go,
    input  logic                timer_done,
    output logic                tick,
    output logic                busy
);

    state_t           state_reg, state_next;
    logic [REP_W-1:0] reps_reg, reps_next;
    logic [REP_W-1:0] done_cnt_reg, done_cnt_next;
    logic             abort_pend_reg, abort_pend_next;
    logic             aborted_reg, aborted_next;

    logic             period_done;
    logic [REP_W-1:0] cnt_inc;

    // A period completes in the first cycle after go (1-cycle timer) or later.
    assign period_done = ((state_reg == ARM) || (state_reg == WAIT)) && timer_done;
    // Never wraps: the count stops at reps_reg.
    assign cnt_inc     = done_cnt_reg + 1'b1;

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.rsp_valid   = (state_reg == RESP);
    assign bus.rsp_count   = done_cnt_reg;
    assign bus.rsp_aborted = aborted_reg;
    assign timer_go        = (state_reg == GO);
    assign busy            = (state_reg != IDLE);
    assign tick            = period_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            reps_reg       <= '0;
            done_cnt_reg   <= '0;
            abort_pend_reg <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            reps_reg       <= reps_next;
            done_cnt_reg   <= done_cnt_next;
            abort_pend_reg <= abort_pend_next;
            aborted_reg    <= aborted_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        reps_next       = reps_reg;
        done_cnt_next   = done_cnt_reg;
        abort_pend_next = abort_pend_reg;
        aborted_next    = aborted_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    reps_next       = bus.cmd_reps;
                    done_cnt_next   = '0;
                    abort_pend_next = 1'b0;
                    aborted_next    = 1'b0;
                    state_next      = (bus.cmd_reps == '0) ? RESP : GO;
                end
            end
            GO: begin
                if (abort) abort_pend_next = 1'b1;
                state_next = ARM;
            end
            ARM, WAIT: begin
                if (abort) abort_pend_next = 1'b1;
                if (timer_done) begin
                    done_cnt_next = cnt_inc;
                    // Reaching the requested count takes priority over abort.
                    if (cnt_inc == reps_reg) begin
                        aborted_next = 1'b0;
                        state_next   = RESP;
                    end else if (abort_pend_reg || abort) begin
                        aborted_next = 1'b1;
                        state_next   = RESP;
                    end else begin
                        state_next = GO;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;
    import timer_pkg::*;

    localparam int REP_W  = 8;
    localparam int CYCLES = 4;
    localparam int PERIOD = CYCLES + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic timer_go;
    logic timer_done;
    logic tick;
    logic busy;

    int errors = 0;
    int checks = 0;

    timer_sequencer_if #(.REP_W(REP_W)) bus ();

    timer_sequencer #(.REP_W(REP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .abort     (abort),
        .timer_go  (timer_go),
        .timer_done(timer_done),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One-shot timer: CYCLES active cycles starting the cycle after go;
    // done while idle and in the final active cycle. Not reset by rst.
    int tcnt = 0;
    always @(posedge clk) begin
        if (timer_go)      tcnt <= CYCLES;
        else if (tcnt != 0) tcnt <= tcnt - 1;
    end
    assign timer_done = (tcnt <= 1);

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Starts at a negedge after the call, offers a command and runs until
    // rsp_valid is seen (returns at that negedge). Cycle k=1 is the first
    // cycle after the accepting edge.
    task automatic run_cmd(input int reps, input int abort_at, input logic ready,
                           output int lat, output int gos, output int ticks,
                           output int spacing_err, output int busy_err);
        int k;
        k = 0; gos = 0; ticks = 0; spacing_err = 0; busy_err = 0; lat = -1;
        @(negedge clk);
        check("cmd_ready_before", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_reps  = REP_W'(reps);
        bus.rsp_ready = ready;
        @(posedge clk);
        while (k < 2000) begin
            @(negedge clk);
            k++;
            bus.cmd_valid = 1'b0;
            abort = (k == abort_at);
            if (timer_go) begin
                gos++;
                if ((k % PERIOD) != 1) spacing_err++;
            end
            if (tick) begin
                ticks++;
                if ((k % PERIOD) != 0) spacing_err++;
            end
            if (bus.rsp_valid) begin
                lat = k;
                abort = 1'b0;
                break;
            end
            if (!busy) busy_err++;
        end
        if (lat < 0) check("rsp_timeout", k, -1);
    endtask

    typedef struct {
        int reps;
        int abort_at;
        int exp_count;
        int exp_aborted;
        int exp_lat;
        int exp_gos;
    } vec_t;

    vec_t vecs[9];
    int lat, gos, ticks, sp_err, b_err;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_reps  = '0;
        bus.rsp_ready = 1'b1;

        // reps, abort cycle (0 = none), count, aborted, latency, go pulses
        vecs[0] = '{3,   0,  3,   0, 16,   3};   // plain run
        vecs[1] = '{0,   0,  0,   0, 1,    0};   // zero reps
        vecs[2] = '{5,   8,  2,   1, 11,   2};   // abort in period 2 WAIT
        vecs[3] = '{2,   10, 2,   0, 11,   2};   // abort with final tick
        vecs[4] = '{1,   1,  1,   0, 6,    1};   // abort in GO, single period
        vecs[5] = '{4,   3,  1,   1, 6,    1};   // abort in period 1 WAIT
        vecs[6] = '{3,   6,  2,   1, 11,   2};   // abort in period 2 GO
        vecs[7] = '{3,   7,  2,   1, 11,   2};   // abort in period 2 ARM
        vecs[8] = '{255, 0,  255, 0, 1276, 255}; // max reps

        repeat (3) @(negedge clk);
        check("rst_cmd_ready",   int'(bus.cmd_ready), 1);
        check("rst_timer_go",    int'(timer_go), 0);
        check("rst_tick",        int'(tick), 0);
        check("rst_rsp_valid",   int'(bus.rsp_valid), 0);
        check("rst_busy",        int'(busy), 0);
        check("rst_rsp_count",   int'(bus.rsp_count), 0);
        check("rst_rsp_aborted", int'(bus.rsp_aborted), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].reps, vecs[i].abort_at, 1'b1, lat, gos, ticks, sp_err, b_err);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_count", i),   int'(bus.rsp_count), vecs[i].exp_count);
            check($sformatf("v%0d_aborted", i), int'(bus.rsp_aborted), vecs[i].exp_aborted);
            check($sformatf("v%0d_gos", i),     gos, vecs[i].exp_gos);
            check($sformatf("v%0d_ticks", i),   ticks, vecs[i].exp_count);
            check($sformatf("v%0d_spacing", i), sp_err, 0);
            check($sformatf("v%0d_busy", i),    b_err, 0);
            $display("vec %0d: reps=%0d abort_at=%0d lat=%0d count=%0d aborted=%0d gos=%0d ticks=%0d",
                     i, vecs[i].reps, vecs[i].abort_at, lat, bus.rsp_count,
                     bus.rsp_aborted, gos, ticks);
        end

        // Response back-pressure: response held, no accept while in RESP.
        run_cmd(1, 0, 1'b0, lat, gos, ticks, sp_err, b_err);
        check("bp_latency", lat, 6);
        bus.cmd_valid = 1'b1;
        bus.cmd_reps  = REP_W'(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rsp_valid",   int'(bus.rsp_valid), 1);
            check("bp_rsp_count",   int'(bus.rsp_count), 1);
            check("bp_rsp_aborted", int'(bus.rsp_aborted), 0);
            check("bp_cmd_ready",   int'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        run_cmd(2, 0, 1'b1, lat, gos, ticks, sp_err, b_err);
        check("bp2_latency", lat, 11);
        check("bp2_count",   int'(bus.rsp_count), 2);
        check("bp2_aborted", int'(bus.rsp_aborted), 0);
        $display("backpressure: second cmd lat=%0d count=%0d", lat, bus.rsp_count);

        // Reset in the middle of a WAIT state.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_reps  = REP_W'(3);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy",      int'(busy), 0);
        check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("mid_rst_timer_go",  int'(timer_go), 0);
        repeat (4) @(negedge clk);
        run_cmd(1, 0, 1'b1, lat, gos, ticks, sp_err, b_err);
        check("post_rst_latency", lat, 6);
        check("post_rst_count",   int'(bus.rsp_count), 1);
        check("post_rst_aborted", int'(bus.rsp_aborted), 0);
        check("post_rst_gos",     gos, 1);
        $display("post-reset: lat=%0d count=%0d", lat, bus.rsp_count);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
